// File: rtl/sqrt_output_wrapper.sv
// Result-side wrapper of the square-root unit: captures the core result, rounds
// (RNE when SQRT_OUT_ROUND_EN is defined, truncation otherwise), resolves specials,
// and holds the result under a valid/ready handshake.
module sqrt_output_wrapper #(
  parameter int ROOT_SIZE  = 54,
  parameter int OUT_M_SIZE = 53,
  parameter int EXP_SIZE   = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ROOT_SIZE-1:0]  in_root,
  input  logic                  in_sticky,
  input  logic [EXP_SIZE-1:0]   in_exp,
  input  logic [2:0]            in_flags,
  input  logic                  in_type,
  input  logic                  in_sign,
  input  logic                  done,
  output logic                  core_ack,
  input  logic                  ready,
  output logic [OUT_M_SIZE-1:0] out_mantisa,
  output logic [EXP_SIZE-1:0]   out_exp,
  output logic [2:0]            out_flags,
  output logic                  out_type,
  output logic                  out_sign,
  output logic                  out_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
`ifdef SQRT_OUT_ROUND_EN
    ROUND = 2'd1,
`endif
    NORM  = 2'd2,
    HOLD  = 2'd3
  } state_t;

`ifdef SQRT_OUT_ROUND_EN
  localparam state_t POST_CAPTURE = ROUND;
`else
  localparam state_t POST_CAPTURE = NORM;
`endif

  state_t                state_q, state_d;
  logic [ROOT_SIZE-1:0]  root_q, root_d;
  logic                  sticky_q, sticky_d;
  logic [EXP_SIZE-1:0]   exp_q, exp_d;
  logic [2:0]            flags_q, flags_d;
  logic                  type_q, type_d;
  logic                  sign_q, sign_d;
  logic [OUT_M_SIZE-1:0] mant_q, mant_d;
  logic [EXP_SIZE-1:0]   oexp_q, oexp_d;
  logic [2:0]            oflags_q, oflags_d;
  logic                  otype_q, otype_d;
  logic                  osign_q, osign_d;
  logic                  valid_q, valid_d;
  logic                  ack_q, ack_d;
  logic                  capture;
  logic                  inexact;
`ifdef SQRT_OUT_ROUND_EN
  logic [OUT_M_SIZE:0]   sum_q, sum_d;
  logic                  inc;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      root_q   <= '0;
      sticky_q <= 1'b0;
      exp_q    <= '0;
      flags_q  <= '0;
      type_q   <= 1'b0;
      sign_q   <= 1'b0;
      mant_q   <= '0;
      oexp_q   <= '0;
      oflags_q <= '0;
      otype_q  <= 1'b0;
      osign_q  <= 1'b0;
      valid_q  <= 1'b0;
      ack_q    <= 1'b0;
`ifdef SQRT_OUT_ROUND_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      root_q   <= root_d;
      sticky_q <= sticky_d;
      exp_q    <= exp_d;
      flags_q  <= flags_d;
      type_q   <= type_d;
      sign_q   <= sign_d;
      mant_q   <= mant_d;
      oexp_q   <= oexp_d;
      oflags_q <= oflags_d;
      otype_q  <= otype_d;
      osign_q  <= osign_d;
      valid_q  <= valid_d;
      ack_q    <= ack_d;
`ifdef SQRT_OUT_ROUND_EN
      sum_q    <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    root_d   = root_q;
    sticky_d = sticky_q;
    exp_d    = exp_q;
    flags_d  = flags_q;
    type_d   = type_q;
    sign_d   = sign_q;
    mant_d   = mant_q;
    oexp_d   = oexp_q;
    oflags_d = oflags_q;
    otype_d  = otype_q;
    osign_d  = osign_q;
    valid_d  = valid_q;
    ack_d    = 1'b0;
    capture  = 1'b0;
    inexact  = root_q[0] | sticky_q;
`ifdef SQRT_OUT_ROUND_EN
    sum_d    = sum_q;
    inc      = root_q[0] & (sticky_q | root_q[1]);
`endif

    case (state_q)
      IDLE: capture = done;
`ifdef SQRT_OUT_ROUND_EN
      ROUND: begin
        sum_d   = {1'b0, root_q[ROOT_SIZE-1 -: OUT_M_SIZE]} + (OUT_M_SIZE+1)'(inc);
        state_d = NORM;
      end
`endif
      NORM: begin
        valid_d = 1'b1;
        state_d = HOLD;
        otype_d = type_q;
        // Specials outrank rounding: negative nonzero/-inf first, then zero, then +inf/NaN.
        if (sign_q & (flags_q[2] | flags_q[0])) begin
          mant_d   = {2'b11, {(OUT_M_SIZE-2){1'b0}}};
          oexp_d   = '1;
          oflags_d = 3'b011;
          osign_d  = 1'b0;
        end else if (flags_q[1]) begin
          mant_d   = '0;
          oexp_d   = '0;
          oflags_d = 3'b000;
          osign_d  = sign_q;
        end else if (flags_q[0]) begin
          mant_d   = root_q[ROOT_SIZE-1 -: OUT_M_SIZE];
          oexp_d   = '1;
          oflags_d = 3'b001;
          osign_d  = sign_q;
        end else begin
          oflags_d = {inexact, 2'b00};
          osign_d  = sign_q;
`ifdef SQRT_OUT_ROUND_EN
          if (sum_q[OUT_M_SIZE]) begin
            mant_d = sum_q[OUT_M_SIZE:1];
            oexp_d = exp_q + EXP_SIZE'(1);
          end else begin
            mant_d = sum_q[OUT_M_SIZE-1:0];
            oexp_d = exp_q;
          end
`else
          mant_d = root_q[ROOT_SIZE-1 -: OUT_M_SIZE];
          oexp_d = exp_q;
`endif
        end
      end
      HOLD: begin
        if (ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
          capture = done;
        end
      end
      default: state_d = IDLE;
    endcase

    // A capture from IDLE or from a HOLD release overrides the state chosen above.
    if (capture) begin
      root_d   = in_root;
      sticky_d = in_sticky;
      exp_d    = in_exp;
      flags_d  = in_flags;
      type_d   = in_type;
      sign_d   = in_sign;
      ack_d    = 1'b1;
      state_d  = POST_CAPTURE;
    end
  end

  assign core_ack    = ack_q;
  assign out_mantisa = mant_q;
  assign out_exp     = oexp_q;
  assign out_flags   = oflags_q;
  assign out_type    = otype_q;
  assign out_sign    = osign_q;
  assign out_valid   = valid_q;

endmodule

// File: tb/tb_sqrt_output_wrapper.sv
// Directed self-checking bench for sqrt_output_wrapper; expectations follow
// SQRT_OUT_ROUND_EN when it is defined, truncation otherwise.
module tb_sqrt_output_wrapper;

`ifdef SQRT_OUT_ROUND_EN
  localparam int LAT = 2;
  localparam logic [52:0] CARRY_MANT = 53'h10000000000000;
  localparam logic [10:0] CARRY_EXP  = 11'h401;
  localparam logic [52:0] TIE3_MANT  = 53'h10000000000002;
`else
  localparam int LAT = 1;
  localparam logic [52:0] CARRY_MANT = 53'h1FFFFFFFFFFFFF;
  localparam logic [10:0] CARRY_EXP  = 11'h400;
  localparam logic [52:0] TIE3_MANT  = 53'h10000000000001;
`endif

  logic        clk;
  logic        rst;
  logic [53:0] in_root;
  logic        in_sticky;
  logic [10:0] in_exp;
  logic [2:0]  in_flags;
  logic        in_type;
  logic        in_sign;
  logic        done;
  logic        core_ack;
  logic        ready;
  logic [52:0] out_mantisa;
  logic [10:0] out_exp;
  logic [2:0]  out_flags;
  logic        out_type;
  logic        out_sign;
  logic        out_valid;

  int checks;
  int failures;

  sqrt_output_wrapper dut (
    .clk(clk), .rst(rst), .in_root(in_root), .in_sticky(in_sticky), .in_exp(in_exp),
    .in_flags(in_flags), .in_type(in_type), .in_sign(in_sign), .done(done),
    .core_ack(core_ack), .ready(ready), .out_mantisa(out_mantisa), .out_exp(out_exp),
    .out_flags(out_flags), .out_type(out_type), .out_sign(out_sign), .out_valid(out_valid)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the directed sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: count it, and on mismatch count and report it
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one core result, check the ack pulse and the capture-to-valid latency
  task automatic applyStimulus(input string tag, input logic [53:0] root, input logic sticky,
                               input logic [10:0] exp, input logic [2:0] flags,
                               input logic typ, input logic sign);
    int n;
    in_root = root; in_sticky = sticky; in_exp = exp;
    in_flags = flags; in_type = typ; in_sign = sign;
    done = 1'b1;
    tick();
    checkOutput({tag, "_ack"}, 64'(core_ack), 64'd1);
    done = 1'b0;
    tick();
    n = 1;
    checkOutput({tag, "_ack_pulse"}, 64'(core_ack), 64'd0);
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    checkOutput({tag, "_latency"}, 64'(n), 64'(LAT));
  endtask

  task automatic checkResult(input string tag, input logic [52:0] mant, input logic [10:0] exp,
                             input logic [2:0] flags, input logic sign);
    checkOutput({tag, "_mant"},  64'(out_mantisa), 64'(mant));
    checkOutput({tag, "_exp"},   64'(out_exp),     64'(exp));
    checkOutput({tag, "_flags"}, 64'(out_flags),   64'(flags));
    checkOutput({tag, "_sign"},  64'(out_sign),    64'(sign));
  endtask

  task automatic releaseResult(input string tag);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checkOutput({tag, "_release"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; done = 1'b0; ready = 1'b0;
    in_root = '0; in_sticky = 1'b0; in_exp = '0; in_flags = '0; in_type = 1'b0; in_sign = 1'b0;
    repeat (3) tick();
    checkOutput("reset_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_ack", 64'(core_ack), 64'd0);
    checkOutput("reset_outs", {out_mantisa, out_exp}, 64'd0);
    checkOutput("reset_side", {out_flags, out_type, out_sign}, 64'd0);
    rst = 1'b1;
    tick();

    applyStimulus("exact", 54'h20000000000000, 1'b0, 11'h3FF, 3'b100, 1'b1, 1'b0);
    checkResult("exact", 53'h10000000000000, 11'h3FF, 3'b000, 1'b0);
    checkOutput("exact_type", 64'(out_type), 64'd1);
    releaseResult("exact");

    applyStimulus("carry", 54'h3FFFFFFFFFFFFF, 1'b1, 11'h400, 3'b100, 1'b0, 1'b0);
    checkResult("carry", CARRY_MANT, CARRY_EXP, 3'b100, 1'b0);
    releaseResult("carry");

    applyStimulus("tie1", 54'h20000000000001, 1'b0, 11'h3FE, 3'b100, 1'b0, 1'b0);
    checkResult("tie1", 53'h10000000000000, 11'h3FE, 3'b100, 1'b0);
    releaseResult("tie1");

    applyStimulus("tie3", 54'h20000000000003, 1'b0, 11'h3FE, 3'b100, 1'b0, 1'b0);
    checkResult("tie3", TIE3_MANT, 11'h3FE, 3'b100, 1'b0);
    releaseResult("tie3");

    applyStimulus("neg", 54'h20000000000000, 1'b0, 11'h3FF, 3'b100, 1'b0, 1'b1);
    checkResult("neg", 53'h18000000000000, 11'h7FF, 3'b011, 1'b0);
    releaseResult("neg");

    applyStimulus("negzero", 54'h3FFFFFFFFFFFFF, 1'b1, 11'h123, 3'b010, 1'b0, 1'b1);
    checkResult("negzero", 53'h0, 11'h0, 3'b000, 1'b1);
    releaseResult("negzero");

    applyStimulus("posinf", 54'h2AAAAAAAAAAAAB, 1'b1, 11'h055, 3'b001, 1'b0, 1'b0);
    checkResult("posinf", 53'h15555555555555, 11'h7FF, 3'b001, 1'b0);
    releaseResult("posinf");

    // Result held for 5 cycles with ready low while the next result waits on done
    applyStimulus("hold", 54'h20000000000000, 1'b0, 11'h3FF, 3'b100, 1'b0, 1'b0);
    in_root = 54'h20000000000003; in_sticky = 1'b0; in_exp = 11'h200;
    in_flags = 3'b100; in_type = 1'b1; in_sign = 1'b0;
    done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkResult("hold_stable", 53'h10000000000000, 11'h3FF, 3'b000, 1'b0);
      checkOutput("hold_valid", 64'(out_valid), 64'd1);
      checkOutput("hold_noack", 64'(core_ack), 64'd0);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checkOutput("b2b_ack", 64'(core_ack), 64'd1);
    checkOutput("b2b_valid_drop", 64'(out_valid), 64'd0);
    done = 1'b0;
    repeat (LAT - 1) begin
      tick();
      checkOutput("b2b_not_yet", 64'(out_valid), 64'd0);
    end
    tick();
    checkOutput("b2b_valid", 64'(out_valid), 64'd1);
    checkResult("b2b", TIE3_MANT, 11'h200, 3'b100, 1'b0);
    checkOutput("b2b_type", 64'(out_type), 64'd1);
    releaseResult("b2b");

    // Asynchronous reset while the core result sits in NORM
    in_root = 54'h3FFFFFFFFFFFFF; in_sticky = 1'b1; in_exp = 11'h400;
    in_flags = 3'b100; in_type = 1'b0; in_sign = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    repeat (LAT - 1) tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_async_outs", {out_mantisa, out_exp}, 64'd0);
    checkOutput("rst_async_side", {out_flags, out_type, out_sign, out_valid, core_ack}, 64'd0);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("rst_no_valid", 64'(out_valid), 64'd0);
    end

    applyStimulus("after_rst", 54'h20000000000000, 1'b0, 11'h3FF, 3'b100, 1'b0, 1'b0);
    checkResult("after_rst", 53'h10000000000000, 11'h3FF, 3'b000, 1'b0);
    releaseResult("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
